// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared definitions for the mmio_responder peripheral:
//               register byte offsets, CTRL bit indices, timer state
//               encoding and the default window base address.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Default window base; the window is 64 bytes and must be 64-byte aligned.
    localparam logic [31:0] MMIO_BASE_ADDR_DEFAULT = 32'hFFFF_FFC0;

    // Register byte offsets inside the window.
    localparam logic [5:0] OFS_SCRATCH = 6'h00;
    localparam logic [5:0] OFS_CYCLE   = 6'h04;
    localparam logic [5:0] OFS_LOAD    = 6'h08;
    localparam logic [5:0] OFS_COUNT   = 6'h0C;
    localparam logic [5:0] OFS_CTRL    = 6'h10;
    localparam logic [5:0] OFS_STATUS  = 6'h14;

    // CTRL bit indices.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit index.
    localparam int STATUS_EXPIRED = 0;

    // Timer state encoding.
    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_DONE = 2'd2
    } tmr_state_e;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Countdown timer owned by mmio_responder. Holds the
//               IDLE/RUN/DONE state machine, the COUNT register and the
//               sticky expired flag.
// Ports       : clock    - clock, rising edge active
//               reset    - asynchronous active-low reset
//               load_val - reload value (LOAD register)
//               start    - CTRL written with en=1
//               stop     - CTRL written with en=0
//               auto     - CTRL.auto, reload on expiry instead of stopping
//               clr      - STATUS written with bit0=1
//               count    - current COUNT value
//               expired  - sticky expiry flag
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] load_val,
    input  logic        start,
    input  logic        stop,
    input  logic        auto,
    input  logic        clr,
    output logic [31:0] count,
    output logic        expired
);

    localparam logic [1:0] c_ST_IDLE = TMR_IDLE;
    localparam logic [1:0] c_ST_RUN  = TMR_RUN;
    localparam logic [1:0] c_ST_DONE = TMR_DONE;

    logic [1:0]  r_state;
    logic [31:0] r_count;
    logic        r_expired;
    logic        w_expire;

    // A stop in the same cycle suppresses the expiry: the timer is leaving RUN.
    assign w_expire = (r_state == c_ST_RUN) && (r_count == 32'd0) && !stop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_count   <= 32'd0;
            r_expired <= 1'b0;
        end else begin
            if (stop) begin
                // COUNT is frozen where it stands.
                r_state <= c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE,
                    c_ST_DONE: begin
                        if (start) begin
                            r_count <= load_val;
                            r_state <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN: begin
                        if (r_count == 32'd0) begin
                            if (auto) begin
                                r_count <= load_val;
                            end else begin
                                r_state <= c_ST_DONE;
                            end
                        end else begin
                            r_count <= r_count - 32'd1;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end

            // Expiry has priority over a software clear in the same cycle.
            if (w_expire) begin
                r_expired <= 1'b1;
            end else if (clr) begin
                r_expired <= 1'b0;
            end
        end
    end

    assign count   = r_count;
    assign expired = r_expired;

endmodule : mmio_timer
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_responder
// Description : Memory-mapped peripheral target on the CPU memory port.
//               Decodes a 64-byte window at BASE_ADDR holding SCRATCH,
//               a free-running CYCLE counter and a countdown timer
//               (LOAD/COUNT/CTRL/STATUS). Reads have one cycle of latency
//               like main memory; rd_hit tells the glue to select rdata.
// Ports       : clock  - clock, rising edge active
//               reset  - asynchronous active-low reset
//               addr   - byte address (addr[1:0] ignored)
//               wr     - write strobe
//               wdata  - store data, full word
//               rdata  - registered read data (0 on a miss)
//               rd_hit - registered: previous address was in the window
//               irq    - timer interrupt request
// Config      : MMIO_IRQ_EN - when defined, CTRL.irq_en is implemented and
//               irq = registered (expired & irq_en); otherwise irq is 0 and
//               CTRL bit2 is not writable.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = MMIO_BASE_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_hit,
    output logic        irq
);

`ifdef MMIO_IRQ_EN
    localparam logic [2:0] c_CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] c_CTRL_MASK = 3'b011;
`endif

    logic        w_hit;
    logic [5:0]  w_ofs;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_status;
    logic        w_unused;
    logic [31:0] w_rdata_next;

    logic [31:0] r_scratch;
    logic [31:0] r_cycle;
    logic [31:0] r_load;
    logic [2:0]  r_ctrl;
    logic [31:0] r_rdata;
    logic        r_rd_hit;

    logic [31:0] w_count;
    logic        w_expired;

    // Word offset with the byte lane bits forced to zero.
    assign w_hit       = (addr[31:6] == BASE_ADDR[31:6]);
    assign w_ofs       = {addr[5:2], 2'b00};
    assign w_unused    = ^addr[1:0];
    assign w_wr        = wr & w_hit;
    assign w_wr_ctrl   = w_wr && (w_ofs == OFS_CTRL);
    assign w_wr_status = w_wr && (w_ofs == OFS_STATUS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scratch <= 32'd0;
            r_cycle   <= 32'd0;
            r_load    <= 32'd0;
            r_ctrl    <= 3'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr && (w_ofs == OFS_SCRATCH)) begin
                r_scratch <= wdata;
            end
            if (w_wr && (w_ofs == OFS_LOAD)) begin
                r_load <= wdata;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= wdata[2:0] & c_CTRL_MASK;
            end
        end
    end

    mmio_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load_val (r_load),
        .start    (w_wr_ctrl & wdata[CTRL_EN]),
        .stop     (w_wr_ctrl & ~wdata[CTRL_EN]),
        .auto     (r_ctrl[CTRL_AUTO]),
        .clr      (w_wr_status & wdata[STATUS_EXPIRED]),
        .count    (w_count),
        .expired  (w_expired)
    );

    // Read mux sees register values as they stand before the sampling edge,
    // so CYCLE reports the count at that edge.
    always_comb begin
        w_rdata_next = 32'd0;
        if (w_hit) begin
            case (w_ofs)
                OFS_SCRATCH: w_rdata_next = r_scratch;
                OFS_CYCLE:   w_rdata_next = r_cycle;
                OFS_LOAD:    w_rdata_next = r_load;
                OFS_COUNT:   w_rdata_next = w_count;
                OFS_CTRL:    w_rdata_next = {29'd0, r_ctrl};
                OFS_STATUS:  w_rdata_next = {31'd0, w_expired};
                default:     w_rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata  <= 32'd0;
            r_rd_hit <= 1'b0;
        end else begin
            r_rdata  <= w_rdata_next;
            r_rd_hit <= w_hit;
        end
    end

    assign rdata  = r_rdata;
    assign rd_hit = r_rd_hit;

`ifdef MMIO_IRQ_EN
    logic r_irq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_expired & r_ctrl[CTRL_IRQ_EN];
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule : mmio_responder
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_responder
// Description : Directed self-checking bench for mmio_responder. Covers
//               reset state, CYCLE timing, SCRATCH read-after-write, window
//               decode, one-shot and auto-reload timer, clear/expiry
//               priority, irq timing and asynchronous reset mid-count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam logic [31:0] c_BASE = 32'hFFFF_FFC0;

`ifdef MMIO_IRQ_EN
    localparam logic        c_IRQ_ON    = 1'b1;
    localparam logic [31:0] c_CTRL7_RDB = 32'd7;
`else
    localparam logic        c_IRQ_ON    = 1'b0;
    localparam logic [31:0] c_CTRL7_RDB = 32'd3;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_hit;
    logic        irq;

    int checks;
    int errors;

    logic [31:0] cyc0;

    mmio_responder #(.BASE_ADDR(c_BASE)) dut (
        .clock  (clock),
        .reset  (reset),
        .addr   (addr),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rd_hit (rd_hit),
        .irq    (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [5:0] ofs, input logic [31:0] data);
        addr  = c_BASE + {26'd0, ofs};
        wr    = 1'b1;
        wdata = data;
        tick();
        wr    = 1'b0;
    endtask

    task automatic rd_reg(input logic [5:0] ofs);
        addr = c_BASE + {26'd0, ofs};
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        addr   = c_BASE + 32'h4;
        wr     = 1'b0;
        wdata  = 32'd0;

        // Reset state
        tick();
        tick();
        check("reset_rdata", rdata, 32'd0);
        check("reset_rd_hit", {31'd0, rd_hit}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Deassert mid-cycle; first sampling edge returns CYCLE=0
        reset = 1'b1;
        tick();
        check("cycle_first", rdata, 32'd0);
        check("cycle_hit", {31'd0, rd_hit}, 32'd1);
        cyc0 = rdata;
        tick();
        tick();
        tick();
        check("cycle_delta", rdata - cyc0, 32'd3);

        rd_reg(6'h00);
        check("scratch_reset", rdata, 32'd0);

        // SCRATCH read-after-write
        wr_reg(6'h00, 32'hDEAD_BEEF);
        tick();
        check("scratch_rdata", rdata, 32'hDEAD_BEEF);
        check("scratch_hit", {31'd0, rd_hit}, 32'd1);

        // Window decode
        addr = 32'h0000_1000;
        tick();
        check("miss_hit", {31'd0, rd_hit}, 32'd0);
        check("miss_rdata", rdata, 32'd0);
        addr = 32'hFFFF_FFBC;
        tick();
        check("below_hit", {31'd0, rd_hit}, 32'd0);
        rd_reg(6'h3C);
        check("unmapped_hit", {31'd0, rd_hit}, 32'd1);
        check("unmapped_rdata", rdata, 32'd0);
        wr_reg(6'h3C, 32'h1234_5678);
        rd_reg(6'h00);
        check("unmapped_wr_ignored", rdata, 32'hDEAD_BEEF);

        // One-shot countdown
        wr_reg(6'h08, 32'd5);
        rd_reg(6'h08);
        check("load_rdb", rdata, 32'd5);
        wr_reg(6'h10, 32'd1);
        addr = c_BASE + 32'h0C;
        for (int i = 5; i >= 0; i--) begin
            tick();
            check("count_down", rdata, 32'(i));
        end
        rd_reg(6'h14);
        check("expired_set", rdata, 32'd1);
        rd_reg(6'h0C);
        check("done_count0", rdata, 32'd0);
        tick();
        check("done_count_hold", rdata, 32'd0);
        rd_reg(6'h10);
        check("ctrl_rdb", rdata, 32'd1);
        wr_reg(6'h14, 32'd1);
        rd_reg(6'h14);
        check("expired_clear", rdata, 32'd0);

        // Auto reload, LOAD=2: expiry every 3 cycles; clear vs expiry
        wr_reg(6'h08, 32'd2);
        wr_reg(6'h10, 32'd3);          // E0: COUNT=2, RUN
        addr = c_BASE + 32'h14;
        tick();                        // E1
        check("auto_e1", rdata, 32'd0);
        tick();                        // E2
        check("auto_e2", rdata, 32'd0);
        tick();                        // E3: expiry
        check("auto_e3", rdata, 32'd0);
        tick();                        // E4
        check("auto_e4", rdata, 32'd1);
        wr = 1'b1;
        wdata = 32'd1;
        tick();                        // E5: clear
        check("auto_e5", rdata, 32'd1);
        wr = 1'b0;
        tick();                        // E6: expiry
        check("auto_e6", rdata, 32'd0);
        tick();                        // E7
        check("auto_e7", rdata, 32'd1);
        wr = 1'b1;
        tick();                        // E8: clear
        tick();                        // E9: clear and expiry together
        check("auto_e9", rdata, 32'd0);
        wr = 1'b0;
        tick();                        // E10
        check("clr_vs_expiry", rdata, 32'd1);

        // Stop: COUNT frozen in IDLE
        wr_reg(6'h10, 32'd0);
        rd_reg(6'h0C);
        cyc0 = rdata;
        tick();
        tick();
        check("idle_frozen", rdata, cyc0);
        wr_reg(6'h14, 32'd1);

        // irq timing with LOAD=1, CTRL=7
        wr_reg(6'h08, 32'd1);
        wr_reg(6'h10, 32'd7);          // E0: COUNT=1, RUN
        addr = c_BASE + 32'h10;
        tick();                        // E1
        check("ctrl7_rdb", rdata, c_CTRL7_RDB);
        check("irq_e1", {31'd0, irq}, 32'd0);
        addr = c_BASE + 32'h14;
        tick();                        // E2: expired sets
        check("irq_e2", {31'd0, irq}, 32'd0);
        tick();                        // E3
        check("status_e3", rdata, 32'd1);
        check("irq_e3", {31'd0, irq}, {31'd0, c_IRQ_ON});

        // Asynchronous reset mid-count
        reset = 1'b0;
        #1;
        check("areset_irq", {31'd0, irq}, 32'd0);
        check("areset_rdata", rdata, 32'd0);
        check("areset_hit", {31'd0, rd_hit}, 32'd0);
        tick();
        reset = 1'b1;
        rd_reg(6'h0C);
        check("post_reset_count", rdata, 32'd0);
        rd_reg(6'h10);
        check("post_reset_ctrl", rdata, 32'd0);
        rd_reg(6'h14);
        check("post_reset_status", rdata, 32'd0);
        check("post_reset_irq", {31'd0, irq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mmio_responder
`default_nettype wire
